// File: rtl/sram_ctrl_pkg.sv
// Shared constants for the SRAM-backed FIFO controller: read latency, output
// buffer depth and the occupancy-counter width helper.
package sram_ctrl_pkg;
  localparam int SRAM_RD_LAT = 1;
  localparam int OBUF_DEPTH  = 2;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + OBUF_DEPTH) + 1;
  endfunction
endpackage

// File: rtl/sram_fifo_obuf.sv
// 2-entry show-ahead register FIFO that hides the SRAM read latency.
// head is the oldest entry; a write and a pop may happen in the same cycle.
module sram_fifo_obuf
  import sram_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [1:0]       cnt,
  output logic [WIDTH-1:0] head
);
  logic [OBUF_DEPTH-1:0][WIDTH-1:0] mem;
  logic hd, tl;

  // With two entries, the tail slot is head when cnt is 0 or 2; a write at
  // cnt=2 only occurs alongside a pop, so it lands in the slot being freed.
  assign tl   = hd ^ cnt[0];
  assign head = mem[hd];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem <= '0;
      hd  <= 1'b0;
      cnt <= '0;
    end else if (clr) begin
      hd  <= 1'b0;
      cnt <= '0;
    end else begin
      if (wr)  mem[tl] <= wdata;
      if (pop) hd      <= ~hd;
      cnt <= cnt + {1'b0, wr} - {1'b0, pop};
    end
  end
endmodule

// File: rtl/sram_fifo_ctrl.sv
// FIFO controller for an external 1R/1W register-file SRAM with a 2-entry
// show-ahead output buffer. Optional empty-FIFO bypass: SRAM_FIFO_BYPASS_EN.
module sram_fifo_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 1024,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [AW+1:0]    count,
  output logic [AW-1:0]    sram_aa,
  output logic             sram_cena,
  input  logic [WIDTH-1:0] sram_qa,
  output logic [AW-1:0]    sram_ab,
  output logic [WIDTH-1:0] sram_db,
  output logic             sram_cenb
);
  localparam int CW = cnt_w(DEPTH);

  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      sram_cnt;
  logic             rd_inflight;
  logic [1:0]       obuf_cnt;
  logic [2:0]       pend;
  logic             push, pop, rd_fire, byp, sram_wr, obuf_wr;
  logic [WIDTH-1:0] obuf_wdata;

  assign in_ready  = (sram_cnt != (AW+1)'(DEPTH));
  assign out_valid = (obuf_cnt != 2'd0);
  // rst gates the strobes so the SRAM enables deassert without a clock edge
  assign push      = in_valid & in_ready & ~clr & ~rst;
  assign pop       = out_valid & out_ready & ~clr;
  assign pend      = {1'b0, obuf_cnt} + {2'b0, rd_inflight} - {2'b0, pop};
  assign rd_fire   = ~clr & ~rst & (sram_cnt != '0) & (pend < 3'd2);

`ifdef SRAM_FIFO_BYPASS_EN
  // Nothing queued in the SRAM path, so skipping it cannot reorder data.
  assign byp = push & (sram_cnt == '0) & ~rd_inflight &
               (({1'b0, obuf_cnt} - {2'b0, pop}) < 3'd2);
`else
  assign byp = 1'b0;
`endif

  assign sram_wr    = push & ~byp;
  assign obuf_wr    = rd_inflight | byp;
  assign obuf_wdata = byp ? in_data : sram_qa;

  assign sram_cenb = ~sram_wr;
  assign sram_ab   = wr_ptr;
  assign sram_db   = in_data;
  assign sram_cena = ~rd_fire;
  assign sram_aa   = rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      sram_cnt    <= '0;
      rd_inflight <= 1'b0;
    end else if (clr) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      sram_cnt    <= '0;
      rd_inflight <= 1'b0;
    end else begin
      if (sram_wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
      sram_cnt    <= sram_cnt + {{AW{1'b0}}, sram_wr} - {{AW{1'b0}}, rd_fire};
      rd_inflight <= rd_fire;
    end
  end

  assign count = CW'(sram_cnt) + CW'(rd_inflight) + CW'(obuf_cnt);

  sram_fifo_obuf #(.WIDTH(WIDTH)) u_obuf (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .wr    (obuf_wr),
    .wdata (obuf_wdata),
    .pop   (pop),
    .cnt   (obuf_cnt),
    .head  (out_data)
  );
endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Bench for sram_fifo_ctrl: SRAM macro model, queue-based reference FIFO and
// per-scenario tasks. Honours SRAM_FIFO_BYPASS_EN for expected latency.
module tb_sram_fifo_ctrl;
  localparam int WIDTH = 16;
  localparam int DEPTH = 1024;
  localparam int AW    = $clog2(DEPTH);
`ifdef SRAM_FIFO_BYPASS_EN
  localparam int   LAT       = 1;
  localparam logic EXP_CENB  = 1'b1;
  localparam logic EXP_CENA1 = 1'b1;
`else
  localparam int   LAT       = 3;
  localparam logic EXP_CENB  = 1'b0;
  localparam logic EXP_CENA1 = 1'b0;
`endif

  logic             clk = 1'b0, rst = 1'b1, clr = 1'b0;
  logic             in_valid = 1'b0, out_ready = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_ready, out_valid, sram_cena, sram_cenb;
  logic [WIDTH-1:0] out_data, sram_db;
  logic [WIDTH-1:0] sram_qa = '0;
  logic [AW+1:0]    count;
  logic [AW-1:0]    sram_aa, sram_ab;

  int checks = 0, errors = 0;
  bit mon_en = 1'b0;
  int unread = 0;
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] sram_mem [DEPTH];

  sram_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count),
    .sram_aa(sram_aa), .sram_cena(sram_cena), .sram_qa(sram_qa),
    .sram_ab(sram_ab), .sram_db(sram_db), .sram_cenb(sram_cenb)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!sram_cenb) sram_mem[sram_ab] <= sram_db;
    if (!sram_cena) sram_qa <= sram_mem[sram_aa];
  end

  // Reference model: a plain queue of accepted words; occupancy = queue size.
  always @(negedge clk) if (mon_en) begin
    checks++;
    if (int'(count) !== q.size()) begin
      errors++; $display("FAIL occupancy: count=%0d model=%0d", count, q.size());
    end
    if (q.size() < DEPTH && !in_ready) begin
      errors++; $display("FAIL in_ready_low: occ=%0d in_ready=%b expected 1", q.size(), in_ready);
    end
    if (q.size() == DEPTH + 2 && in_ready) begin
      errors++; $display("FAIL in_ready_full: occ=%0d in_ready=%b expected 0", q.size(), in_ready);
    end
    if (clr) begin
      q.delete(); unread = 0;
    end else begin
      if (!sram_cena) begin
        checks++;
        if (unread == 0) begin
          errors++; $display("FAIL rd_empty: read issued with %0d unread SRAM words, need >0", unread);
        end
      end
      if (!sram_cenb) unread++;
      if (!sram_cena) unread--;
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0 || out_data !== q[0]) begin
          errors++;
          $display("FAIL pop_data: got %h expected %h (model size %0d)", out_data,
                   (q.size() != 0) ? q[0] : 16'hxxxx, q.size());
        end
        if (q.size() != 0) void'(q.pop_front());
      end
      if (in_valid && in_ready) q.push_back(in_data);
    end
  end

  task test_reset;
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: %b expected 0", out_valid); end
    checks++; if (sram_cena !== 1'b1) begin errors++; $display("FAIL rst_cena: %b expected 1", sram_cena); end
    checks++; if (sram_cenb !== 1'b1) begin errors++; $display("FAIL rst_cenb: %b expected 1", sram_cenb); end
    checks++; if (count !== '0) begin errors++; $display("FAIL rst_count: %0d expected 0", count); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL rst_out_data: %h expected 0", out_data); end
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;
  endtask

  task test_single;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 16'h00A5; out_ready = 1'b1;
    @(negedge clk);
    checks++; if (sram_cenb !== EXP_CENB) begin errors++; $display("FAIL single_cenb: %b expected %b", sram_cenb, EXP_CENB); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) begin
        checks++; if (sram_cena !== EXP_CENA1) begin errors++; $display("FAIL single_cena: %b expected %b", sram_cena, EXP_CENA1); end
      end
      checks++;
      if (out_valid !== (k == LAT)) begin
        errors++; $display("FAIL single_latency: t+%0d out_valid=%b expected %b", k, out_valid, k == LAT);
      end else if (out_valid && out_data !== 16'h00A5) begin
        errors++; $display("FAIL single_data: %h expected 00a5", out_data);
      end
    end
    checks++; if (count !== '0) begin errors++; $display("FAIL single_count: %0d expected 0", count); end
  endtask

  task test_fill;
    int acc = 0, cyc = 0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    while (acc < DEPTH + 2 && cyc < 4000) begin
      in_valid = 1'b1; in_data = WIDTH'(acc);
      @(negedge clk);
      if (in_ready) acc++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    checks++; if (acc != DEPTH + 2) begin errors++; $display("FAIL fill_accepted: %0d expected %0d", acc, DEPTH + 2); end
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready: %b expected 0", in_ready); end
    checks++; if (count !== (AW+2)'(DEPTH + 2)) begin errors++; $display("FAIL fill_count: %0d expected %0d", count, DEPTH + 2); end
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int j = 0; j < DEPTH + 2; j++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== WIDTH'(j)) begin
        errors++; $display("FAIL drain_order: idx %0d valid=%b data=%h expected %h", j, out_valid, out_data, WIDTH'(j));
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++; if (count !== '0) begin errors++; $display("FAIL drain_count: %0d expected 0", count); end
  endtask

  task test_stream;
    int acc = 0, pops = 0, gaps = 0, cyc = 0;
    bit seen = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    while (acc < 5000 && cyc < 10000) begin
      in_valid = 1'b1; in_data = WIDTH'($urandom);
      @(negedge clk);
      if (in_ready) acc++;
      if (out_valid) begin seen = 1'b1; pops++; end
      else if (seen) gaps++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    checks++; if (gaps != 0) begin errors++; $display("FAIL stream_gaps: %0d bubbles expected 0", gaps); end
    checks++; if (cyc != 5000) begin errors++; $display("FAIL stream_rate: %0d cycles for 5000 pushes expected 5000", cyc); end
    cyc = 0;
    do begin
      @(negedge clk);
      if (out_valid) pops++;
      @(posedge clk); #1;
      cyc++;
    end while (count != 0 && cyc < 50);
    checks++; if (pops != 5000) begin errors++; $display("FAIL stream_pops: %0d expected 5000", pops); end
  endtask

  task test_random;
    int acc = 0, pops = 0, cyc = 0;
    @(posedge clk); #1;
    while (acc < 10000 && cyc < 40000) begin
      in_valid = $urandom_range(0, 1) != 0; in_data = WIDTH'($urandom);
      out_ready = $urandom_range(0, 1) != 0;
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      if (out_valid && out_ready) pops++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    cyc = 0;
    while (count != 0 && cyc < 3000) begin
      @(negedge clk);
      if (out_valid) pops++;
      @(posedge clk); #1;
      cyc++;
    end
    checks++; if (acc != 10000) begin errors++; $display("FAIL random_pushes: %0d expected 10000", acc); end
    checks++; if (pops != acc) begin errors++; $display("FAIL random_pops: %0d expected %0d", pops, acc); end
  endtask

  task test_clr;
    bit found = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; in_data = WIDTH'(16'h0100 + i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    out_ready = 1'b1; in_valid = 1'b1; in_data = 16'h0107;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0; clr = 1'b1;
    @(negedge clk);
    checks++; if (count !== (AW+2)'(7)) begin errors++; $display("FAIL clr_pre_count: %0d expected 7", count); end
    @(posedge clk); #1;
    clr = 1'b0;
    @(negedge clk);
    checks++; if (count !== '0) begin errors++; $display("FAIL clr_count: %0d expected 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clr_out_valid: %b expected 0", out_valid); end
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 16'h1234; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (out_valid) found = 1'b1;
      else begin @(posedge clk); #1; end
    end
    checks++;
    if (!found || out_data !== 16'h1234) begin
      errors++; $display("FAIL clr_first_word: valid=%b data=%h expected 1234", found, out_data);
    end
    @(posedge clk); #1;
  endtask

  task test_async_rst;
    in_valid = 1'b1; out_ready = 1'b1;
    repeat (20) begin
      in_data = WIDTH'($urandom);
      out_ready = $urandom_range(0, 1) != 0;
      @(posedge clk); #1;
    end
    #2;
    checks++; if (count === '0) begin errors++; $display("FAIL arst_precond: count=%0d expected nonzero", count); end
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if (sram_cena !== 1'b1) begin errors++; $display("FAIL arst_cena: %b expected 1", sram_cena); end
    checks++; if (sram_cenb !== 1'b1) begin errors++; $display("FAIL arst_cenb: %b expected 1", sram_cenb); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_out_valid: %b expected 0", out_valid); end
    checks++; if (count !== '0) begin errors++; $display("FAIL arst_count: %0d expected 0", count); end
    in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete(); unread = 0;
    mon_en = 1'b1;
    @(negedge clk);
    checks++; if (count !== '0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL arst_after: count=%0d valid=%b expected 0/0", count, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_stream();
    test_random();
    test_clr();
    test_async_rst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/sram_fifo_ctrl.md
Name: sram_fifo_ctrl

Overview:
- FIFO controller that drives an external 1-write/1-read register-file SRAM macro: port B writes, port A reads, chip enables active-low, read data on QA one cycle after CENA low.
- Presents valid/ready push and show-ahead pop interfaces to CNN datapath stages.
- Hides SRAM read latency with a 2-entry output buffer, sustaining 1 push + 1 pop per cycle.
- The parent instantiates the SRAM macro and wires it to the sram_* ports.

Parameters:
- WIDTH, 16, data word width; must match SRAM word width.
- DEPTH, 1024, SRAM depth; power of two, >= 4.
- AW, $clog2(DEPTH), address width (localparam, not overridable).

Ports:
- clk  input  1  single clock for controller and both SRAM ports.
- rst  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous flush.
- in_valid  input  1  push request.
- in_ready  output  1  push accepted when in_valid & in_ready.
- in_data  input  WIDTH  push data.
- out_valid  output  1  out_data holds head entry.
- out_ready  input  1  pop when out_valid & out_ready.
- out_data  output  WIDTH  head entry (show-ahead).
- count  output  AW+2  total occupancy, 0..DEPTH+2.
- sram_aa  output  AW  read address.
- sram_cena  output  1  read enable, active-low.
- sram_qa  input  WIDTH  read data, valid one cycle after sram_cena=0.
- sram_ab  output  AW  write address.
- sram_db  output  WIDTH  write data.
- sram_cenb  output  1  write enable, active-low.

Behaviour:
- State:
  - wr_ptr, rd_ptr (AW bits, natural wrap at DEPTH).
  - sram_cnt (AW+1 bits, 0..DEPTH).
  - rd_inflight flag.
  - obuf: 2-entry FIFO, obuf_cnt 0..2.
- Reset values: pointers, counters, rd_inflight, obuf_cnt = 0; out_valid=0; sram_cena=1; sram_cenb=1; count=0; out_data=0.
- Push:
  - in_ready = (sram_cnt != DEPTH).
  - On push: sram_cenb=0, sram_ab=wr_ptr, sram_db=in_data (combinational), wr_ptr++, sram_cnt++ at the edge.
- Read issue:
  - rd_fire = (sram_cnt != 0) & (obuf_cnt + rd_inflight - pop < 2).
  - On rd_fire: sram_cena=0, sram_aa=rd_ptr, rd_ptr++, sram_cnt--; rd_inflight <= rd_fire.
- Capture: when rd_inflight=1, sram_qa is written into the obuf tail at that edge.
- Pop: out_valid = (obuf_cnt != 0); out_data = obuf head; a pop frees the head.
- Simultaneous push and rd_fire: sram_cnt unchanged.
  - A read never targets the address written in the same cycle, because sram_cnt counts only committed writes.
- count = sram_cnt + rd_inflight + obuf_cnt.
- Latency: push accepted at cycle t -> out_valid at t+3 (empty FIFO, no bypass).
- Throughput: 1 word/cycle in steady state with out_ready held high.
- Full: in_ready=0 at sram_cnt=DEPTH. Max total occupancy is DEPTH+2.
- Empty: out_valid=0, sram_cena=1. A pop with out_valid=0 is ignored.
- clr: overrides push, pop, and rd_fire in that cycle.
  - Pointers, counters, obuf_cnt, and rd_inflight return to 0; sram_cena=sram_cenb=1.
  - Any in-flight QA is discarded.
- Reset mid-operation: all contents are lost. SRAM contents are irrelevant after reset.

Optional Feature:
- Macro: SRAM_FIFO_BYPASS_EN.
- Defined: when sram_cnt=0, rd_inflight=0, and obuf has a free slot after this cycle's pop, a push goes directly into obuf and skips the SRAM write (sram_cenb stays 1).
  - Empty-FIFO latency becomes 1 cycle (push at t -> out_valid at t+1).
  - Ordering is preserved because bypass requires no data pending in the SRAM path.
- Undefined: every push goes through the SRAM; latency is 3.

Decomposition:
- Shared package sram_ctrl_pkg:
  - SRAM_RD_LAT=1 constant.
  - OBUF_DEPTH=2 constant.
  - Count-width function cnt_w(depth)=$clog2(depth+OBUF_DEPTH)+1.
- One sub-module sram_fifo_obuf: 2-entry show-ahead register FIFO with write/pop/clr, exposing cnt and head.

Test Plan:
- Reset, then push 1 word 0x00A5, out_ready=1 -> sram_cenb=0 at t, sram_cena=0 at t+1, out_valid=1 with out_data=0x00A5 at t+3 (t+1 with SRAM_FIFO_BYPASS_EN); count returns to 0 after pop.
- out_ready=0, push DEPTH+2=1026 words 0..1025 -> in_ready drops after word 1025 is accepted, count=1026; then drain -> 0..1025 in order, no gaps once out_ready=1.
- Continuous push and pop of 5000 words, out_ready=1 -> steady-state one word per cycle, ordering intact, pointers wrap past 1023 correctly.
- Random in_valid/out_ready (50% each), 10000 words -> scoreboard matches, count equals model occupancy every cycle, no read issued while sram_cnt=0.
- Assert clr while rd_inflight=1 and count=7 -> next cycle count=0, out_valid=0, in-flight QA not captured; a subsequent push of 0x1234 emerges first.
- Assert rst asynchronously mid-stream -> outputs take their reset values immediately (sram_cena=sram_cenb=1, out_valid=0) without waiting for a clock edge.
